// File: rtl/handshake_pkg.sv
// handshake_pkg: state encoding shared by the valid/ready handshake slices
package handshake_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
endpackage

// File: rtl/forward_registered_slice_if.sv
// forward_registered_slice_if: valid/ready/data channel; master drives vaild+data and samples ready, slave the reverse
interface forward_registered_slice_if #(
  parameter int WIDTH = 8
);
  logic vaild;
  logic [WIDTH-1:0] data;
  logic ready;
  modport master (output vaild, data, input ready);
  modport slave (input vaild, data, output ready);
endinterface

// File: rtl/forward_registered_slice.sv
// forward_registered_slice: two-entry fully registered valid/ready slice; ports clk, s_rst (sync active-low), src (slave side), dst (master side), occupancy (entries held)
module forward_registered_slice
  import handshake_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic s_rst,
  forward_registered_slice_if.slave  src,
  forward_registered_slice_if.master dst,
  output logic [1:0] occupancy
);
  state_t state, state_n;
  logic [WIDTH-1:0] main_q, main_n, skid_q, skid_n;
  logic src_ready_q, dst_vaild_q, acc, xfr;
  assign acc = src.vaild & src_ready_q;
  assign xfr = dst_vaild_q & dst.ready;
  always_comb begin
    state_n = state;
    main_n = main_q;
    skid_n = skid_q;
    case (state)
      EMPTY: if (acc) begin
        main_n = src.data;
        state_n = ONE;
      end
      ONE: if (acc && xfr) main_n = src.data;
      else if (acc) begin
        skid_n = src.data;
        state_n = FULL;
      end
      else if (xfr) state_n = EMPTY;
      FULL: if (xfr) begin
        main_n = skid_q;
        state_n = ONE;
      end
      default: state_n = EMPTY;
    endcase
  end
  // handshake flags are registered from the next state so no output depends combinationally on an input
  always_ff @(posedge clk) begin
    if (!s_rst) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      src_ready_q <= 1'b1;
      dst_vaild_q <= 1'b0;
    end else begin
      state <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
      src_ready_q <= state_n != FULL;
      dst_vaild_q <= state_n != EMPTY;
    end
  end
  assign src.ready = src_ready_q;
  assign dst.vaild = dst_vaild_q;
  assign dst.data = main_q;
  assign occupancy = state;
endmodule

// File: tb/tb_forward_registered_slice.sv
// tb_forward_registered_slice: directed and random stimulus against a count/queue reference model with a decoupled scoreboard
module tb_forward_registered_slice;
  logic clk = 1'b0;
  logic s_rst = 1'b0;
  logic [1:0] occupancy;
  forward_registered_slice_if #(.WIDTH(8)) src_if ();
  forward_registered_slice_if #(.WIDTH(8)) dst_if ();
  forward_registered_slice #(.WIDTH(8)) dut (
    .clk(clk),
    .s_rst(s_rst),
    .src(src_if),
    .dst(dst_if),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  int m_occ = 0;
  bit armed = 1'b0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // reference model: the slice is a 2-deep FIFO; acceptance when fewer than 2 held, delivery when any held
  always @(posedge clk) begin : model
    bit acc, xfr;
    if (!s_rst) begin
      m_occ = 0;
      exp_q.delete();
      armed = 1'b1;
    end else if (armed) begin
      acc = src_if.vaild && m_occ < 2;
      xfr = dst_if.ready && m_occ > 0;
      if (acc) exp_q.push_back(src_if.data);
      m_occ = m_occ + int'(acc) - int'(xfr);
    end
  end
  always @(negedge clk) if (armed)
    check("flags", {29'd0, occupancy, src_if.ready, dst_if.vaild},
          {29'd0, 2'(m_occ), m_occ != 2, m_occ != 0});
  always @(negedge clk) if (armed && s_rst && dst_if.vaild && dst_if.ready) begin
    if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
    else check("sb_data", dst_if.data, exp_q.pop_front());
  end
  task automatic drive(bit v, logic [7:0] d, bit r);
    src_if.vaild = v;
    src_if.data = d;
    dst_if.ready = r;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(1'b1, 8'hEE, 1'b0);
    repeat (3) tick();
    check("rst_vaild", dst_if.vaild, 0);
    check("rst_ready", src_if.ready, 1);
    check("rst_occ", occupancy, 0);
    check("rst_data", dst_if.data, 8'h00);
    s_rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      tick();
      check("stream_vaild", dst_if.vaild, 1);
      check("stream_data", dst_if.data, i);
      check("stream_ready", src_if.ready, 1);
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    check("stream_empty", occupancy, 0);
    drive(1'b1, 8'hA1, 1'b0);
    tick();
    drive(1'b1, 8'hA2, 1'b0);
    tick();
    drive(1'b1, 8'hA3, 1'b0);
    tick();
    check("bp_occ", occupancy, 2);
    check("bp_ready", src_if.ready, 0);
    check("bp_data", dst_if.data, 8'hA1);
    tick();
    check("bp_hold_data", dst_if.data, 8'hA1);
    check("bp_hold_vaild", dst_if.vaild, 1);
    drive(1'b1, 8'hA3, 1'b1);
    tick();
    check("bp_rel_a2", dst_if.data, 8'hA2);
    check("bp_rel_occ", occupancy, 1);
    tick();
    check("bp_rel_a3", dst_if.data, 8'hA3);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    check("bp_drained", occupancy, 0);
    drive(1'b1, 8'h55, 1'b0);
    tick();
    check("sim_main", dst_if.data, 8'h55);
    drive(1'b1, 8'h66, 1'b1);
    tick();
    check("sim_data", dst_if.data, 8'h66);
    check("sim_occ", occupancy, 1);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b1, 8'hC1, 1'b0);
    tick();
    drive(1'b1, 8'hC2, 1'b0);
    tick();
    check("mid_full", occupancy, 2);
    s_rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    check("mid_occ", occupancy, 0);
    check("mid_vaild", dst_if.vaild, 0);
    s_rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) tick();
    check("mid_no_c", dst_if.vaild, 0);
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom));
      tick();
    end
    drive(1'b0, 8'h00, 1'b1);
    repeat (4) tick();
    check("rand_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/forward_registered_slice.md
FORWARD_REGISTERED_SLICE -- requirements
Module: forward_registered_slice

Interface
REQ-001 Parameter WIDTH, default 8, is the payload width in bits.
REQ-002 clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-003 s_rst  input  1  is the reset: synchronous, active-low (0 = reset asserted).
REQ-004 src_vaild  input  1  indicates the upstream source presents valid data.
REQ-005 src_data_in  input  WIDTH  is the upstream payload.
REQ-006 src_ready  output  1  indicates the slice can accept upstream data this cycle; it is driven directly from a flop.
REQ-007 dst_vaild  output  1  indicates the slice presents valid data downstream; it is driven directly from a flop.
REQ-008 dst_data_out  output  WIDTH  is the downstream payload; it is driven directly from a flop.
REQ-009 dst_ready  input  1  indicates the downstream sink accepts data this cycle.
REQ-010 occupancy  output  2  is the number of entries held (0, 1 or 2); it is driven directly from a flop.

Function
REQ-011 An upstream transfer (acc) SHALL occur when src_vaild=1 and src_ready=1; a downstream transfer (xfr) SHALL occur when dst_vaild=1 and dst_ready=1.
REQ-012 The slice SHALL hold two WIDTH-bit entries: a main register driving dst_data_out and a skid register.
REQ-013 The state machine SHALL have three states: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid).
REQ-014 EMPTY: acc -> main<=src_data_in, go to ONE; no acc -> stay in EMPTY.
REQ-015 ONE: acc&xfr -> main<=src_data_in, stay in ONE; acc only -> skid<=src_data_in, go to FULL; xfr only -> go to EMPTY; neither -> hold.
REQ-016 FULL: xfr -> main<=skid, go to ONE; no xfr -> hold both entries.
REQ-017 src_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, so acc never occurs in FULL.
REQ-018 dst_vaild SHALL be 1 in ONE and FULL and 0 in EMPTY.
REQ-019 Latency from acc to dst_vaild SHALL be exactly one cycle when the slice is EMPTY.
REQ-020 Sustained throughput SHALL be one transfer per cycle when src_vaild=1 and dst_ready=1 continuously.
REQ-021 Data order SHALL be strictly FIFO; no entry is dropped or duplicated.
REQ-022 dst_data_out and dst_vaild SHALL remain stable while dst_vaild=1 and dst_ready=0.
REQ-023 dst_data_out SHALL retain its last value in EMPTY; it carries no meaning while dst_vaild=0.
REQ-024 No output SHALL have a combinational path from any input.

Reset
REQ-025 While s_rst=0 at a rising edge, state SHALL become EMPTY, occupancy 0, dst_vaild 0, src_ready 1, and the main and skid registers 0.
REQ-026 Reset asserted mid-operation SHALL discard all held entries at that edge, even if an acc or xfr is coincident.
REQ-027 The first acc SHALL be possible in the first cycle after s_rst returns to 1.

Structure
REQ-028 The state encoding constants (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) SHALL reside in the shared package handshake_pkg, which the handshake slices share.
REQ-029 The block SHALL be a single module with no sub-module; occupancy SHALL equal the state encoding.

Verification
REQ-030 Reset: hold s_rst=0 for 3 cycles with src_vaild=1 -> dst_vaild=0, src_ready=1, occupancy=0, dst_data_out=8'h00.
REQ-031 Streaming: send 8'h01..8'h10 back-to-back with dst_ready=1 -> the same 16 values appear on consecutive cycles starting 1 cycle after the first acc, src_ready stays 1.
REQ-032 Backpressure: send 8'hA1,8'hA2,8'hA3 with dst_ready=0 -> A1 and A2 accepted, occupancy=2, src_ready=0, A3 held upstream, dst_data_out=A1 stable; release dst_ready -> A1,A2,A3 delivered in order.
REQ-033 Simultaneous events in ONE: main=8'h55, acc 8'h66 with xfr in the same cycle -> next cycle dst_data_out=8'h66, occupancy=1.
REQ-034 Reset mid-operation: occupancy=2 holding 8'hC1,8'hC2, pulse s_rst=0 for 1 cycle -> occupancy=0, dst_vaild=0; neither C1 nor C2 ever appears downstream.
REQ-035 Random: random src_vaild/dst_ready at 50% over 10000 cycles -> scoreboard shows in-order, lossless delivery; src_ready/dst_vaild/occupancy match the REQ-013 to REQ-018 reference model every cycle.
